// File: rtl/four_bit_serial_loader.sv
// Serial-to-parallel front end for the 4-bit D register stage: collects a
// framed MSB-first word plus optional parity bit and delivers it with a load strobe.
module four_bit_serial_loader #(
    parameter logic PARITY_EN  = 1'b1,
    parameter logic ODD_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       serial_in,
    output logic [3:0] d_out,
    output logic       load,
    output logic       busy,
    output logic       parity_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] cnt_r, cnt_s;
    logic [3:0] shreg_r, shreg_s;
    logic [3:0] d_out_r, d_out_s;
    logic       load_r, load_s;
    logic       busy_r;
    logic       perr_r, perr_s;

    // High when the data ones plus the parity bit do not match the selected parity sense.
    function automatic logic parity_fail(input logic [3:0] data, input logic pbit, input logic odd);
        return (((^data) ^ pbit) != odd);
    endfunction

    // Next-state, shift/count and delivery decisions.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shreg_s = shreg_r;
        d_out_s = d_out_r;
        load_s  = 1'b0;
        perr_s  = perr_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                    cnt_s   = 3'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                shreg_s = {shreg_r[2:0], serial_in};
                cnt_s   = (cnt_r >= 3'd4) ? 3'd4 : (cnt_r + 3'd1);
                // cnt_r == 3 means this edge samples the fourth data bit
                if (cnt_r >= 3'd3) begin
                    if (PARITY_EN) begin
                        state_s = PARITY;
                    end else begin
                        state_s = IDLE;
                        d_out_s = {shreg_r[2:0], serial_in};
                        load_s  = 1'b1;
                        perr_s  = 1'b0;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            PARITY: begin
                state_s = IDLE;
                d_out_s = shreg_r;
                load_s  = 1'b1;
                perr_s  = parity_fail(shreg_r, serial_in, ODD_PARITY);
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            shreg_r <= 4'b0000;
            d_out_r <= 4'b0000;
            load_r  <= 1'b0;
            busy_r  <= 1'b0;
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shreg_r <= shreg_s;
            d_out_r <= d_out_s;
            load_r  <= load_s;
            busy_r  <= (state_s != IDLE);
            perr_r  <= perr_s;
        end
    end

    assign d_out      = d_out_r;
    assign load       = load_r;
    assign busy       = busy_r;
    assign parity_err = perr_r;

endmodule

// File: tb/tb_four_bit_serial_loader.sv
// Bench for four_bit_serial_loader: a frame-level model checked every cycle on
// both a parity-enabled and a parity-less instance, plus literal expectations.
module tb_four_bit_serial_loader;

    localparam logic ODD = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, serial_in, start2, serial_in2;
    logic [3:0] d_out, d_out2;
    logic       load, busy, parity_err, load2, busy2, parity_err2;

    four_bit_serial_loader #(.PARITY_EN(1'b1), .ODD_PARITY(ODD)) u_dut (
        .clk(clk), .rst(rst), .start(start), .serial_in(serial_in),
        .d_out(d_out), .load(load), .busy(busy), .parity_err(parity_err)
    );

    four_bit_serial_loader #(.PARITY_EN(1'b0), .ODD_PARITY(ODD)) u_dut_np (
        .clk(clk), .rst(rst), .start(start2), .serial_in(serial_in2),
        .d_out(d_out2), .load(load2), .busy(busy2), .parity_err(parity_err2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: a frame is the start cycle followed by LEN sampled bits.
    bit         m_act[2];
    int         m_cnt[2];
    logic [4:0] m_bits[2];
    logic [3:0] e_d[2];
    logic       e_load[2], e_busy[2], e_perr[2];

    always @(posedge clk) begin
        logic st_v[2];
        logic si_v[2];
        int   len;
        int   ones;
        st_v[0] = start;  si_v[0] = serial_in;
        st_v[1] = start2; si_v[1] = serial_in2;
        started = 1'b1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            len = (i == 0) ? 5 : 4;
            if (!rst) begin
                m_act[i] = 1'b0; m_cnt[i] = 0; e_d[i] = 4'b0000;
                e_load[i] = 1'b0; e_busy[i] = 1'b0; e_perr[i] = 1'b0;
            end else begin
                e_load[i] = 1'b0;
                if (m_act[i]) begin
                    m_bits[i][m_cnt[i]] = si_v[i];
                    m_cnt[i]++;
                    if (m_cnt[i] == len) begin
                        e_d[i] = {m_bits[i][0], m_bits[i][1], m_bits[i][2], m_bits[i][3]};
                        e_load[i] = 1'b1;
                        m_act[i] = 1'b0;
                        ones = int'(m_bits[i][0]) + int'(m_bits[i][1]) + int'(m_bits[i][2]) + int'(m_bits[i][3]);
                        if (i == 0) begin
                            ones += int'(m_bits[i][4]);
                            e_perr[i] = ((ones % 2) != int'(ODD));
                        end else begin
                            e_perr[i] = 1'b0;
                        end
                    end
                end else if (st_v[i]) begin
                    m_act[i] = 1'b1;
                    m_cnt[i] = 0;
                end
                e_busy[i] = m_act[i];
            end
        end
    end

    int         load_t[$];
    logic [3:0] load_d[$];

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("d_out",       d_out,                {3'b000, 1'b0} | e_d[0]);
            chk("load",        {3'b000, load},       {3'b000, e_load[0]});
            chk("busy",        {3'b000, busy},       {3'b000, e_busy[0]});
            chk("parity_err",  {3'b000, parity_err}, {3'b000, e_perr[0]});
            chk("np_d_out",    d_out2,               e_d[1]);
            chk("np_load",     {3'b000, load2},      {3'b000, e_load[1]});
            chk("np_busy",     {3'b000, busy2},      {3'b000, e_busy[1]});
            chk("np_parity",   {3'b000, parity_err2},{3'b000, e_perr[1]});
            if (load === 1'b1) begin
                load_t.push_back(cyc);
                load_d.push_back(d_out);
            end
        end
    end

    task automatic step(input logic st, input logic si);
        start = st; serial_in = si; start2 = 1'b0; serial_in2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic step2(input logic st, input logic si);
        start = 1'b0; serial_in = 1'b0; start2 = st; serial_in2 = si;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [3:0] w, input logic p);
        logic r;
        r = 1'($urandom_range(0, 1));
        step(1'b1, r);
        for (int i = 3; i >= 0; i--) step(1'b0, w[i]);
        step(1'b0, p);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; serial_in = 1'b0; start2 = 1'b0; serial_in2 = 1'b0;
        repeat (2) begin
            start = 1'($urandom_range(0, 1)); serial_in = 1'($urandom_range(0, 1));
            start2 = 1'($urandom_range(0, 1)); serial_in2 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("rst_d_out", d_out, 4'b0000);
            chk("rst_load", {3'b000, load}, 4'b0000);
            chk("rst_busy", {3'b000, busy}, 4'b0000);
            chk("rst_perr", {3'b000, parity_err}, 4'b0000);
        end
        rst = 1'b1;
        step(1'b0, 1'b1);

        frame(4'b1011, 1'b1);
        chk("clean_load", {3'b000, load}, 4'b0001);
        chk("clean_d_out", d_out, 4'b1011);
        chk("clean_perr", {3'b000, parity_err}, 4'b0000);
        chk("clean_busy", {3'b000, busy}, 4'b0000);
        step(1'b0, 1'b0);
        chk("clean_load_once", {3'b000, load}, 4'b0000);
        chk("clean_hold", d_out, 4'b1011);

        frame(4'b1011, 1'b0);
        chk("perr_load", {3'b000, load}, 4'b0001);
        chk("perr_d_out", d_out, 4'b1011);
        chk("perr_set", {3'b000, parity_err}, 4'b0001);
        step(1'b0, 1'b1);
        chk("perr_held", {3'b000, parity_err}, 4'b0001);
        frame(4'b0110, 1'b0);
        chk("perr_clear", {3'b000, parity_err}, 4'b0000);
        chk("perr_clear_d", d_out, 4'b0110);

        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b1);
        chk("midrst_d_out", d_out, 4'b0000);
        chk("midrst_busy", {3'b000, busy}, 4'b0000);
        chk("midrst_load", {3'b000, load}, 4'b0000);
        rst = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("midrst_noload", {3'b000, load}, 4'b0000);
        frame(4'b0001, 1'b1);
        chk("after_rst_d", d_out, 4'b0001);
        chk("after_rst_perr", {3'b000, parity_err}, 4'b0000);
        step(1'b0, 1'b0);

        load_t.delete();
        load_d.delete();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("ignored_start_busy", {3'b000, busy}, 4'b0001);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        frame(4'b1100, 1'b0);
        step(1'b0, 1'b0);
        chk("b2b_count", 4'(load_t.size()), 4'd2);
        if (load_t.size() == 2) begin
            chk("b2b_gap", 4'(load_t[1] - load_t[0]), 4'd6);
            chk("b2b_first", load_d[0], 4'b1010);
            chk("b2b_second", load_d[1], 4'b1100);
        end

        step2(1'b1, 1'b1);
        step2(1'b0, 1'b0);
        step2(1'b0, 1'b1);
        step2(1'b0, 1'b1);
        step2(1'b0, 1'b1);
        chk("np_load_lit", {3'b000, load2}, 4'b0001);
        chk("np_d_lit", d_out2, 4'b0111);
        chk("np_perr_lit", {3'b000, parity_err2}, 4'b0000);
        step2(1'b0, 1'b1);
        chk("np_load_once", {3'b000, load2}, 4'b0000);
        chk("np_hold", d_out2, 4'b0111);
        step2(1'b0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
